vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between the display fetch path (driven from the 800x600 timing generator's x/y) and a CPU bus master. The display always wins, so scanout never misses a slot. CPU writes are posted through a one-entry write buffer. CPU reads stall until the RAM is free.
It sits between the text/pixel fetch logic, the CPU data bus and the VRAM macro.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_arbiter_if.sv | 18 +
 rtl/vram_wbuf.sv | 58 +++++
 rtl/vram_arbiter.sv | 107 ++++++++++
 tb/tb_vram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter slice.
package vram_pkg;
    localparam int unsigned AW_DEF     = 13;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned STAT_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DPY  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wbuf_state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// CPU bus into the VRAM arbiter: valid/ready request channel plus read return.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) ();
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer; a push while draining replaces the entry.
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          drain,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    wbuf_state_t   state, state_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= WB_EMPTY;
            addr  <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        data_nxt  = data;
        unique case (state)
            WB_EMPTY: begin
                if (push) begin
                    state_nxt = WB_FULL;
                    addr_nxt  = push_addr;
                    data_nxt  = push_data;
                end
            end
            WB_FULL: begin
                if (push) begin
                    addr_nxt = push_addr;
                    data_nxt = push_data;
                end else if (drain) begin
                    state_nxt = WB_EMPTY;
                end
            end
        endcase
    end

    assign full = (state == WB_FULL);
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display > buffered CPU write > CPU read.
// Optional statistics counters under `define VRAM_ARB_STAT_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
`ifdef VRAM_ARB_STAT_EN
    ,
    parameter int unsigned STAT_W = STAT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              dpy_req,
    input  logic [AW-1:0]     dpy_addr,
    output logic              dpy_rvalid,
    output logic [DW-1:0]     dpy_rdata,
    vram_arbiter_if.slave     cpu,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
`ifdef VRAM_ARB_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_dpy_reads,
    output logic [STAT_W-1:0] stat_cpu_stall
`endif
);
    owner_t        owner, owner_nxt;
    logic          wb_full;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          drain;
    logic          push;
    logic          rd_grant;

    // Reads wait for an empty buffer so a read never overtakes a posted write.
    assign drain     = wb_full && !dpy_req;
    assign cpu.ready = cpu.we ? (!wb_full || drain) : (!dpy_req && !wb_full);
    assign push      = cpu.valid && cpu.we && cpu.ready;
    assign rd_grant  = cpu.valid && !cpu.we && cpu.ready;

    vram_wbuf #(
        .AW(AW),
        .DW(DW)
    ) u_wbuf (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (push),
        .push_addr(cpu.addr),
        .push_data(cpu.wdata),
        .drain    (drain),
        .full     (wb_full),
        .addr     (wb_addr),
        .data     (wb_data)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_nxt = OWN_NONE;
        if (dpy_req) begin
            mem_en    = 1'b1;
            mem_addr  = dpy_addr;
            owner_nxt = OWN_DPY;
        end else if (wb_full) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wb_addr;
            mem_wdata = wb_data;
        end else if (rd_grant) begin
            mem_en    = 1'b1;
            mem_addr  = cpu.addr;
            owner_nxt = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) owner <= OWN_NONE;
        else        owner <= owner_nxt;
    end

    // RAM output is already registered, so the tag alone times the return.
    assign dpy_rvalid = (owner == OWN_DPY);
    assign dpy_rdata  = dpy_rvalid ? mem_rdata : '0;
    assign cpu.rvalid = (owner == OWN_CPU);
    assign cpu.rdata  = cpu.rvalid ? mem_rdata : '0;

`ifdef VRAM_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (!n_rst || stat_clr) begin
            stat_dpy_reads <= '0;
            stat_cpu_stall <= '0;
        end else begin
            if (dpy_req && (stat_dpy_reads != '1))
                stat_dpy_reads <= stat_dpy_reads + STAT_W'(1);
            if (cpu.valid && !cpu.ready && (stat_cpu_stall != '1))
                stat_cpu_stall <= stat_cpu_stall + STAT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a 1-cycle-latency RAM model.
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          dpy_req;
    logic [AW-1:0] dpy_addr;
    logic          dpy_rvalid;
    logic [DW-1:0] dpy_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STAT_EN
    logic          stat_clr;
    logic [15:0]   stat_dpy_reads;
    logic [15:0]   stat_cpu_stall;
`endif

    int total = 0;
    int bad   = 0;

    vram_arbiter_if #(.AW(AW), .DW(DW)) cpu_bus ();

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .dpy_req   (dpy_req),
        .dpy_addr  (dpy_addr),
        .dpy_rvalid(dpy_rvalid),
        .dpy_rdata (dpy_rdata),
        .cpu       (cpu_bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef VRAM_ARB_STAT_EN
        ,
        .stat_clr      (stat_clr),
        .stat_dpy_reads(stat_dpy_reads),
        .stat_cpu_stall(stat_cpu_stall)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: unwritten words read back as 0xC000 + address.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            ram_set [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return ram_set[a] ? ram[a] : (16'hC000 + 16'(a));
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                ram_set[mem_addr] <= 1'b1;
            end else begin
                ram_q <= ram_val(mem_addr);
            end
        end
    end
    assign mem_rdata = ram_q;

    typedef struct {
        logic          dq;
        logic [AW-1:0] da;
        logic          cv;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          en;
        logic          we;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic          rdy;
        logic          dv;
        logic [DW-1:0] dd;
        logic          cvl;
        logic [DW-1:0] cdat;
    } vec_t;

    function automatic vec_t mk(input int dq, input int da, input int cv, input int cw,
                                input int ca, input int cd, input int en, input int we,
                                input int ma, input int md, input int rdy, input int dv,
                                input int dd, input int cvl, input int cdat);
        vec_t r;
        r.dq = dq[0]; r.da = AW'(da); r.cv = cv[0]; r.cw = cw[0];
        r.ca = AW'(ca); r.cd = DW'(cd); r.en = en[0]; r.we = we[0];
        r.ma = AW'(ma); r.md = DW'(md); r.rdy = rdy[0]; r.dv = dv[0];
        r.dd = DW'(dd); r.cvl = cvl[0]; r.cdat = DW'(cdat);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dq, input logic [AW-1:0] da, input logic cv,
                         input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        dpy_req       = dq;
        dpy_addr      = da;
        cpu_bus.valid = cv;
        cpu_bus.we    = cw;
        cpu_bus.addr  = ca;
        cpu_bus.wdata = cd;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[20];
        int   pulses;

        vt[0]  = mk(0, 0,      1, 1, 'h0123, 'hBEEF, 0, 0, 0,      0,      1, 0, 0,      0, 0);
        vt[1]  = mk(0, 0,      0, 0, 0,      0,      1, 1, 'h0123, 'hBEEF, 0, 0, 0,      0, 0);
        vt[2]  = mk(0, 0,      1, 0, 'h0123, 0,      1, 0, 'h0123, 0,      1, 0, 0,      0, 0);
        vt[3]  = mk(0, 0,      0, 0, 0,      0,      0, 0, 0,      0,      1, 0, 0,      1, 'hBEEF);
        vt[4]  = mk(1, 'h0200, 1, 0, 'h0010, 0,      1, 0, 'h0200, 0,      0, 0, 0,      0, 0);
        vt[5]  = mk(0, 0,      1, 0, 'h0010, 0,      1, 0, 'h0010, 0,      1, 1, 'hC200, 0, 0);
        vt[6]  = mk(1, 'h0201, 1, 0, 'h0011, 0,      1, 0, 'h0201, 0,      0, 0, 0,      1, 'hC010);
        vt[7]  = mk(0, 0,      1, 0, 'h0011, 0,      1, 0, 'h0011, 0,      1, 1, 'hC201, 0, 0);
        vt[8]  = mk(0, 0,      0, 0, 0,      0,      0, 0, 0,      0,      1, 0, 0,      1, 'hC011);
        vt[9]  = mk(0, 0,      1, 0, 'h0020, 0,      1, 0, 'h0020, 0,      1, 0, 0,      0, 0);
        vt[10] = mk(0, 0,      1, 0, 'h0021, 0,      1, 0, 'h0021, 0,      1, 0, 0,      1, 'hC020);
        vt[11] = mk(0, 0,      0, 0, 0,      0,      0, 0, 0,      0,      1, 0, 0,      1, 'hC021);
        vt[12] = mk(0, 0,      1, 1, 'h0100, 'h1111, 0, 0, 0,      0,      1, 0, 0,      0, 0);
        vt[13] = mk(1, 'h0300, 1, 1, 'h0101, 'h2222, 1, 0, 'h0300, 0,      0, 0, 0,      0, 0);
        vt[14] = mk(0, 0,      1, 1, 'h0101, 'h2222, 1, 1, 'h0100, 'h1111, 1, 1, 'hC300, 0, 0);
        vt[15] = mk(0, 0,      1, 0, 'h0100, 0,      1, 1, 'h0101, 'h2222, 0, 0, 0,      0, 0);
        vt[16] = mk(0, 0,      1, 0, 'h0100, 0,      1, 0, 'h0100, 0,      1, 0, 0,      0, 0);
        vt[17] = mk(0, 0,      0, 0, 0,      0,      0, 0, 0,      0,      1, 0, 0,      1, 'h1111);
        vt[18] = mk(1, 'h0101, 0, 0, 0,      0,      1, 0, 'h0101, 0,      0, 0, 0,      0, 0);
        vt[19] = mk(0, 0,      0, 0, 0,      0,      0, 0, 0,      0,      1, 1, 'h2222, 0, 0);

        // Reset, then idle
        n_rst = 1'b0;
`ifdef VRAM_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        drive(0, '0, 0, 0, '0, '0);
        repeat (3) next();
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d.mem_en", i), 32'(mem_en), 0);
            chk($sformatf("idle%0d.ready", i), 32'(cpu_bus.ready), 1);
            chk($sformatf("idle%0d.dpy_rvalid", i), 32'(dpy_rvalid), 0);
            chk($sformatf("idle%0d.cpu_rvalid", i), 32'(cpu_bus.rvalid), 0);
            next();
        end

        // Table vectors
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].dq, vt[i].da, vt[i].cv, vt[i].cw, vt[i].ca, vt[i].cd);
            @(negedge clk);
            chk($sformatf("v%0d.mem_en", i), 32'(mem_en), 32'(vt[i].en));
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vt[i].we));
            if (vt[i].en) chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vt[i].ma));
            if (vt[i].we) chk($sformatf("v%0d.mem_wdata", i), 32'(mem_wdata), 32'(vt[i].md));
            chk($sformatf("v%0d.cpu_ready", i), 32'(cpu_bus.ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d.dpy_rvalid", i), 32'(dpy_rvalid), 32'(vt[i].dv));
            chk($sformatf("v%0d.dpy_rdata", i), 32'(dpy_rdata), 32'(vt[i].dd));
            chk($sformatf("v%0d.cpu_rvalid", i), 32'(cpu_bus.rvalid), 32'(vt[i].cvl));
            chk($sformatf("v%0d.cpu_rdata", i), 32'(cpu_bus.rdata), 32'(vt[i].cdat));
            next();
        end

        // Display burst of 8 while the buffer holds a write
        drive(0, '0, 1, 1, 13'h0400, 16'hABCD);
        @(negedge clk);
        chk("burst.accept", 32'(cpu_bus.ready), 1);
        next();
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 13'(13'h0500 + k), 1, 1, 13'h0401, 16'h1234);
            @(negedge clk);
            chk($sformatf("burst%0d.ready", k), 32'(cpu_bus.ready), 0);
            chk($sformatf("burst%0d.mem_we", k), 32'(mem_we), 0);
            chk($sformatf("burst%0d.mem_addr", k), 32'(mem_addr), 32'(13'h0500 + k));
            chk($sformatf("burst%0d.dpy_rvalid", k), 32'(dpy_rvalid), (k == 0) ? 0 : 1);
            if (k > 0) chk($sformatf("burst%0d.dpy_rdata", k), 32'(dpy_rdata), 32'h0000C500 + 32'(k - 1));
            if (dpy_rvalid) pulses++;
            next();
        end
        drive(0, '0, 1, 1, 13'h0401, 16'h1234);
        @(negedge clk);
        chk("burst.drain_we", 32'(mem_we), 1);
        chk("burst.drain_addr", 32'(mem_addr), 32'h0400);
        chk("burst.drain_data", 32'(mem_wdata), 32'hABCD);
        chk("burst.refill_ready", 32'(cpu_bus.ready), 1);
        chk("burst.last_rdata", 32'(dpy_rdata), 32'hC507);
        if (dpy_rvalid) pulses++;
        next();
        drive(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("burst.drain2_addr", 32'(mem_addr), 32'h0401);
        chk("burst.drain2_data", 32'(mem_wdata), 32'h1234);
        if (dpy_rvalid) pulses++;
        chk("burst.pulses", 32'(pulses), 8);
        next();

        // Streaming writes, one per cycle
        for (int i = 0; i < 16; i++) begin
            drive(0, '0, 1, 1, 13'(13'h0600 + i), 16'(16'h7000 + i));
            @(negedge clk);
            chk($sformatf("stream%0d.ready", i), 32'(cpu_bus.ready), 1);
            if (i > 0) begin
                chk($sformatf("stream%0d.mem_we", i), 32'(mem_we), 1);
                chk($sformatf("stream%0d.mem_addr", i), 32'(mem_addr), 32'h0600 + 32'(i - 1));
            end
            next();
        end
        drive(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("stream.last_addr", 32'(mem_addr), 32'h060F);
        next();
        next();
        for (int i = 0; i < 16; i++)
            chk($sformatf("stream.ram%0d", i), 32'(ram_val(13'(13'h0600 + i))), 32'h7000 + 32'(i));

`ifdef VRAM_ARB_STAT_EN
        stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat.clr_dpy", 32'(stat_dpy_reads), 0);
        chk("stat.clr_stall", 32'(stat_cpu_stall), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 13'h0010, 0, 0, '0, '0);
            next();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 13'h0010, 1, 0, 13'h0020, '0);
            next();
        end
        drive(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("stat.dpy", 32'(stat_dpy_reads), 5);
        chk("stat.stall", 32'(stat_cpu_stall), 2);
        next();
`endif

        // Reset on the edge that ends a read grant: no return may follow
        drive(0, '0, 1, 0, 13'h0700, '0);
        n_rst = 1'b0;
        next();
        n_rst = 1'b1;
        drive(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("rst.cpu_rvalid", 32'(cpu_bus.rvalid), 0);
        chk("rst.cpu_rdata", 32'(cpu_bus.rdata), 0);
        next();

        // Reset discards a buffered write held back by the display
        drive(1, '0, 1, 1, 13'h0701, 16'h5A5A);
        @(negedge clk);
        chk("rst.buf_accept", 32'(cpu_bus.ready), 1);
        next();
        n_rst = 1'b0;
        drive(1, '0, 0, 0, '0, '0);
        next();
        n_rst = 1'b1;
        drive(0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d.mem_en", i), 32'(mem_en), 0);
            chk($sformatf("rst%0d.ready", i), 32'(cpu_bus.ready), 1);
            chk($sformatf("rst%0d.dpy_rvalid", i), 32'(dpy_rvalid), 0);
`ifdef VRAM_ARB_STAT_EN
            if (i == 0) begin
                chk("rst.stat_dpy", 32'(stat_dpy_reads), 0);
                chk("rst.stat_stall", 32'(stat_cpu_stall), 0);
            end
`endif
            next();
        end
        chk("rst.ram_untouched", 32'(ram_val(13'h0701)), 32'hC701);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
